celery_fp_divider: RTL and testbench

CELERY_FP_DIVIDER -- requirements
Module: celery_fp_divider

---
 rtl/celery_pkg.sv | 18 +
 rtl/celery_fp_divider.sv | 213 +++++++++++++++++++++
 tb/tb_celery_fp_divider.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/celery_pkg.sv
// Shared definitions for the celery fixed-point divider: FSM states,
// default operand format and saturation limits for that format.
package celery_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 16;

  localparam logic [DEF_WIDTH-1:0] FP_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] FP_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

endpackage

// File: rtl/celery_fp_divider.sv
// Signed fixed-point divider: restoring radix-2 on magnitudes, one quotient
// bit per cycle, then sign application and saturation before a held result.
module celery_fp_divider
  import celery_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_den,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic             out_div_zero,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int M  = WIDTH + FRAC;
  localparam int CW = $clog2(M + 1);

  localparam logic [WIDTH-1:0] SAT_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [M-1:0]     MAG_POS_LIM = M'(SAT_MAX);
  localparam logic [M-1:0]     MAG_NEG_LIM = M'(SAT_MIN);
  localparam logic [CW-1:0]    LAST_STEP   = CW'(M - 1);

  state_e             state_q, state_d;
  logic [M-1:0]       acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   den_q, den_d;
  logic               neg_q, neg_d;
  logic               dz_q, dz_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         fix_cnt_q, fix_cnt_d;

  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_quot_q, out_quot_d;
  logic               out_dz_q, out_dz_d;
  logic               out_ovf_q, out_ovf_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;

  logic [WIDTH-1:0]   num_mag;
  logic [WIDTH-1:0]   den_mag;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     den_ext;
  logic [WIDTH:0]     rem_sub;
  logic               rem_ge;
  logic [WIDTH-1:0]   fix_quot;
  logic               fix_ovf;

  // Magnitudes are taken as unsigned, so the most-negative value maps to 2^(WIDTH-1).
  always_comb begin
    num_mag   = in_num[WIDTH-1] ? -in_num : in_num;
    den_mag   = in_den[WIDTH-1] ? -in_den : in_den;
    rem_shift = {rem_q[WIDTH-1:0], acc_q[M-1]};
    den_ext   = {1'b0, den_q};
    rem_ge    = (rem_shift >= den_ext);
    rem_sub   = rem_shift - den_ext;
  end

  always_comb begin
    fix_quot = '0;
    fix_ovf  = 1'b0;
    if (dz_q) begin
      fix_quot = '0;
    end else if (!neg_q) begin
      if (acc_q > MAG_POS_LIM) begin
        fix_quot = SAT_MAX;
        fix_ovf  = 1'b1;
      end else begin
        fix_quot = acc_q[WIDTH-1:0];
      end
    end else begin
      if (acc_q > MAG_NEG_LIM) begin
        fix_quot = SAT_MIN;
        fix_ovf  = 1'b1;
      end else begin
        fix_quot = -acc_q[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    den_d       = den_q;
    neg_d       = neg_q;
    dz_d        = dz_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    fix_cnt_d   = fix_cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_quot_d  = out_quot_q;
    out_dz_d    = out_dz_q;
    out_ovf_d   = out_ovf_q;
    out_tag_d   = out_tag_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d      = M'(num_mag) << FRAC;
          rem_d      = '0;
          den_d      = den_mag;
          neg_d      = in_num[WIDTH-1] ^ in_den[WIDTH-1];
          tag_d      = in_tag;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          if (in_den == '0) begin
            dz_d      = 1'b1;
            fix_cnt_d = 2'd2;
            state_d   = ST_FIX;
          end else begin
            dz_d    = 1'b0;
            state_d = ST_DIV;
          end
        end
      end

      ST_DIV: begin
        acc_d = {acc_q[M-2:0], rem_ge};
        rem_d = rem_ge ? rem_sub : rem_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          fix_cnt_d = 2'd1;
          state_d   = ST_FIX;
        end
      end

      // The settle count pads both paths to their fixed result latency.
      ST_FIX: begin
        if (fix_cnt_q != 2'd0) begin
          fix_cnt_d = fix_cnt_q - 1'b1;
        end else begin
          out_quot_d  = fix_quot;
          out_ovf_d   = fix_ovf;
          out_dz_d    = dz_q;
          out_tag_d   = tag_q;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      den_q       <= '0;
      neg_q       <= 1'b0;
      dz_q        <= 1'b0;
      tag_q       <= '0;
      cnt_q       <= '0;
      fix_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_quot_q  <= '0;
      out_dz_q    <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      den_q       <= den_d;
      neg_q       <= neg_d;
      dz_q        <= dz_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      fix_cnt_q   <= fix_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_quot_q  <= out_quot_d;
      out_dz_q    <= out_dz_d;
      out_ovf_q   <= out_ovf_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_quot     = out_quot_q;
  assign out_div_zero = out_dz_q;
  assign out_ovf      = out_ovf_q;
  assign out_tag      = out_tag_q;

endmodule

// File: tb/tb_celery_fp_divider.sv
// Directed self-checking bench for celery_fp_divider at WIDTH=32, FRAC=16.
module tb_celery_fp_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_num;
  logic [31:0] in_den;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_quot;
  logic        out_div_zero;
  logic        out_ovf;
  logic [3:0]  out_tag;

  int checks = 0;
  int fails  = 0;

  celery_fp_divider #(.WIDTH(32), .FRAC(16), .TAG_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_num       (in_num),
    .in_den       (in_den),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quot     (out_quot),
    .out_div_zero (out_div_zero),
    .out_ovf      (out_ovf),
    .out_tag      (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request, scrambles inputs after the accept edge, and waits
  // (bounded) for out_valid; lat counts rising edges after the accept edge.
  task automatic run_req(input logic [31:0] n, input logic [31:0] d, input logic [3:0] t,
                         output logic [31:0] q, output logic dz, output logic ov,
                         output logic [3:0] tg, output int lat);
    @(negedge clk);
    in_num   = n;
    in_den   = d;
    in_tag   = t;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_num   = $urandom;
    in_den   = $urandom;
    in_tag   = 4'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q  = out_quot;
    dz = out_div_zero;
    ov = out_ovf;
    tg = out_tag;
    $display("txn num=%h den=%h tag=%0d -> quot=%h dz=%b ovf=%b tag=%0d lat=%0d",
             n, d, t, q, dz, ov, tg, lat);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_num    = '0;
    in_den    = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if ({out_quot, out_div_zero, out_ovf, out_tag} !== 38'd0) begin
      fails++;
      $display("FAIL reset_outputs: got quot=%h dz=%b ovf=%b tag=%h expected all zero",
               out_quot, out_div_zero, out_ovf, out_tag);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] q; logic dz, ov; logic [3:0] tg; int lat;
    run_req(32'h0001_0000, 32'h0002_0000, 4'd1, q, dz, ov, tg, lat);
    checks++;
    if (q !== 32'h0000_8000) begin fails++; $display("FAIL basic_quot: got %h expected 00008000", q); end
    checks++;
    if ({dz, ov} !== 2'b00) begin fails++; $display("FAIL basic_flags: got dz=%b ovf=%b expected 0 0", dz, ov); end
    checks++;
    if (lat !== 50) begin fails++; $display("FAIL basic_latency: got %0d expected 50", lat); end
    checks++;
    if (tg !== 4'd1) begin fails++; $display("FAIL basic_tag: got %0d expected 1", tg); end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_release: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_sign_trunc();
    logic [31:0] q; logic dz, ov; logic [3:0] tg; int lat;
    run_req(32'h0003_0000, 32'hFFFE_0000, 4'd2, q, dz, ov, tg, lat);
    checks++;
    if (q !== 32'hFFFE_8000 || ov !== 1'b0) begin
      fails++; $display("FAIL neg_quot: got %h ovf=%b expected fffe8000 ovf=0", q, ov);
    end
    consume();
    run_req(32'h0001_0000, 32'h0003_0000, 4'd3, q, dz, ov, tg, lat);
    checks++;
    if (q !== 32'h0000_5555) begin fails++; $display("FAIL trunc_quot: got %h expected 00005555", q); end
    consume();
    run_req(32'hFFFF_0000, 32'h0003_0000, 4'd4, q, dz, ov, tg, lat);
    checks++;
    if (q !== 32'hFFFF_AAAB) begin fails++; $display("FAIL trunc_neg_quot: got %h expected ffffaaab", q); end
    consume();
  endtask

  task automatic test_saturation();
    logic [31:0] q; logic dz, ov; logic [3:0] tg; int lat;
    run_req(32'h7FFF_0000, 32'h0000_0100, 4'd6, q, dz, ov, tg, lat);
    checks++;
    if (q !== 32'h7FFF_FFFF || ov !== 1'b1) begin
      fails++; $display("FAIL sat_pos: got %h ovf=%b expected 7fffffff ovf=1", q, ov);
    end
    consume();
    run_req(32'h8000_0000, 32'h0001_0000, 4'd7, q, dz, ov, tg, lat);
    checks++;
    if (q !== 32'h8000_0000 || ov !== 1'b0) begin
      fails++; $display("FAIL most_neg_exact: got %h ovf=%b expected 80000000 ovf=0", q, ov);
    end
    consume();
    run_req(32'h8000_0000, 32'h0000_8000, 4'd8, q, dz, ov, tg, lat);
    checks++;
    if (q !== 32'h8000_0000 || ov !== 1'b1) begin
      fails++; $display("FAIL sat_neg: got %h ovf=%b expected 80000000 ovf=1", q, ov);
    end
    consume();
  endtask

  task automatic test_div_zero();
    logic [31:0] q; logic dz, ov; logic [3:0] tg; int lat;
    run_req(32'h1234_0000, 32'h0000_0000, 4'd5, q, dz, ov, tg, lat);
    checks++;
    if (q !== 32'h0 || dz !== 1'b1) begin
      fails++; $display("FAIL dz_result: got %h dz=%b expected 00000000 dz=1", q, dz);
    end
    checks++;
    if (tg !== 4'd5) begin fails++; $display("FAIL dz_tag: got %0d expected 5", tg); end
    checks++;
    if (lat !== 3) begin fails++; $display("FAIL dz_latency: got %0d expected 3", lat); end
    consume();
  endtask

  task automatic test_backpressure();
    logic [31:0] q; logic dz, ov; logic [3:0] tg; int lat;
    int bad;
    run_req(32'h0002_0000, 32'h0001_0000, 4'd10, q, dz, ov, tg, lat);
    checks++;
    if (q !== 32'h0002_0000) begin fails++; $display("FAIL bp_quot: got %h expected 00020000", q); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_num   = $urandom;
      in_den   = $urandom;
      in_tag   = 4'($urandom);
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_quot !== 32'h0002_0000 ||
          out_tag !== 4'd10 || out_ovf !== 1'b0 || out_div_zero !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    consume();
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rq [2];
    logic [3:0]  rt [2];
    int nres;
    logic take;
    nres = 0;
    @(negedge clk);
    in_num    = 32'h0003_0000;
    in_den    = 32'hFFFE_0000;
    in_tag    = 4'd3;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_num = 32'h0001_0000;
    in_den = 32'h0003_0000;
    in_tag = 4'd9;
    for (int cyc = 0; cyc < 300 && nres < 2; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        rq[nres] = out_quot;
        rt[nres] = out_tag;
        $display("txn b2b result %0d quot=%h tag=%0d", nres, out_quot, out_tag);
        nres++;
      end
      take = in_ready && in_valid;
      @(posedge clk);
      #1;
      if (take) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (nres !== 2) begin
      fails++; $display("FAIL b2b_count: got %0d results expected 2", nres);
    end else begin
      checks++;
      if (rq[0] !== 32'hFFFE_8000 || rt[0] !== 4'd3) begin
        fails++; $display("FAIL b2b_first: got %h tag=%0d expected fffe8000 tag=3", rq[0], rt[0]);
      end
      checks++;
      if (rq[1] !== 32'h0000_5555 || rt[1] !== 4'd9) begin
        fails++; $display("FAIL b2b_second: got %h tag=%0d expected 00005555 tag=9", rq[1], rt[1]);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] q; logic dz, ov; logic [3:0] tg; int lat;
    @(negedge clk);
    in_num   = 32'h7FFF_0000;
    in_den   = 32'h0000_0100;
    in_tag   = 4'd12;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset_ctrl: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    checks++;
    if ({out_quot, out_div_zero, out_ovf, out_tag} !== 38'd0) begin
      fails++; $display("FAIL mid_reset_outputs: got quot=%h tag=%h expected zero", out_quot, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_req(32'h0001_0000, 32'h0002_0000, 4'd14, q, dz, ov, tg, lat);
    checks++;
    if (q !== 32'h0000_8000 || ov !== 1'b0 || dz !== 1'b0 || tg !== 4'd14) begin
      fails++; $display("FAIL after_reset_result: got %h ovf=%b dz=%b tag=%0d expected 00008000 0 0 14", q, ov, dz, tg);
    end
    checks++;
    if (lat !== 50) begin fails++; $display("FAIL after_reset_latency: got %0d expected 50", lat); end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_trunc();
    test_saturation();
    test_div_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
